// File: rtl/mem_cache_pkg.sv
// mem_cache_pkg: shared FSM state type and default geometry for mem_cache_sa
//   DEF_DW/DEF_AW/DEF_SETS/DEF_WAYS : default data width, address width, set count, associativity
//   state_t                         : controller states
package mem_cache_pkg;
   localparam int DEF_DW   = 8;
   localparam int DEF_AW   = 6;
   localparam int DEF_SETS = 4;
   localparam int DEF_WAYS = 2;
   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_DONE} state_t;
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: valid/tag/data storage, hit compare and victim choice for one indexed set
//   clk, reset          : clock, async active-high reset (clears valid bits and round-robin pointers)
//   i_flush             : clear every valid bit
//   i_idx, i_tag        : set index and tag of the current access
//   i_wr, i_wdata       : overwrite data of the hit way (write hit)
//   i_fill, i_fill_data : allocate the victim way with i_tag/i_fill_data
//   o_hit, o_rdata      : hit flag and data of the hit way
module cache_way_array #(
   parameter int DW   = 8,
   parameter int TW   = 4,
   parameter int SETS = 4,
   parameter int WAYS = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_flush,
   input  logic [$clog2(SETS)-1:0]  i_idx,
   input  logic [TW-1:0]            i_tag,
   input  logic                     i_wr,
   input  logic [DW-1:0]            i_wdata,
   input  logic                     i_fill,
   input  logic [DW-1:0]            i_fill_data,
   output logic                     o_hit,
   output logic [DW-1:0]            o_rdata
);
   localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
   logic [SETS-1:0][WAYS-1:0] r_valid;
   logic [SETS-1:0][WW-1:0]   r_rr;
   logic [TW-1:0]             r_tag  [SETS][WAYS];
   logic [DW-1:0]             r_data [SETS][WAYS];
   logic [WW-1:0]             w_victim, w_hit_way;
   // Descending scan so the lowest matching way wins
   always_comb begin
      o_hit     = 1'b0;
      w_hit_way = '0;
      o_rdata   = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (r_valid[i_idx][w] && r_tag[i_idx][w] == i_tag) begin
            o_hit     = 1'b1;
            w_hit_way = WW'(w);
            o_rdata   = r_data[i_idx][w];
         end
   end
   // First invalid way beats the round-robin pointer
   always_comb begin
      w_victim = r_rr[i_idx];
      for (int w = WAYS - 1; w >= 0; w--)
         if (!r_valid[i_idx][w]) w_victim = WW'(w);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_valid <= '0;
         r_rr    <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (i_fill) begin
         r_valid[i_idx][w_victim] <= 1'b1;
         r_rr[i_idx] <= (r_rr[i_idx] == WW'(WAYS - 1)) ? '0 : r_rr[i_idx] + 1'b1;
      end
   always_ff @(posedge clk)
      if (i_fill) begin
         r_tag[i_idx][w_victim]  <= i_tag;
         r_data[i_idx][w_victim] <= i_fill_data;
      end else if (i_wr && o_hit) begin
         r_data[i_idx][w_hit_way] <= i_wdata;
      end
endmodule

// File: rtl/mem_cache_sa.sv
// mem_cache_sa: set-associative write-through, no-write-allocate cache with round-robin replacement
//   clk, reset                  : clock, async active-high reset
//   req, RWB, Address, Data     : CPU request (held until ready), 1=read, word address, write data
//   flush                       : invalidate-all pulse, honoured only in IDLE
//   MemSysOut, ready, Hit       : read data, one-cycle completion pulse, hit flag
//   mem_req/rwb/addr/wdata      : backing-memory request, held until mem_ack
//   mem_rdata, mem_ack          : backing-memory response
//   hit_cnt, acc_cnt            : saturating statistics, built only with MEM_CACHE_STATS_EN defined
module mem_cache_sa
   import mem_cache_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int AW   = DEF_AW,
   parameter int SETS = DEF_SETS,
   parameter int WAYS = DEF_WAYS
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          RWB,
   input  logic [AW-1:0] Address,
   input  logic [DW-1:0] Data,
   input  logic          flush,
   output logic [DW-1:0] MemSysOut,
   output logic          ready,
   output logic          Hit,
   output logic          mem_req,
   output logic          mem_rwb,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [15:0]   hit_cnt,
   output logic [15:0]   acc_cnt
);
   localparam int IW = $clog2(SETS);
   localparam int TW = AW - IW;
   state_t        r_state, w_next;
   logic          r_rwb, r_hit;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata, r_dout, w_rdata;
   logic          w_accept, w_flush, w_fill, w_wr, w_hit;
   // flush wins over a simultaneous req
   assign w_accept = (r_state == S_IDLE) && req && !flush;
   assign w_flush  = (r_state == S_IDLE) && flush;
   assign w_fill   = (r_state == S_MEM_RD) && mem_ack;
   assign w_wr     = (r_state == S_LOOKUP) && !r_rwb;
   cache_way_array #(.DW(DW), .TW(TW), .SETS(SETS), .WAYS(WAYS)) u_ways (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (w_flush),
      .i_idx       (r_addr[IW-1:0]),
      .i_tag       (r_addr[AW-1:IW]),
      .i_wr        (w_wr),
      .i_wdata     (r_wdata),
      .i_fill      (w_fill),
      .i_fill_data (mem_rdata),
      .o_hit       (w_hit),
      .o_rdata     (w_rdata)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:             w_next = w_accept ? S_LOOKUP : S_IDLE;
         S_LOOKUP:           w_next = !r_rwb ? S_MEM_WR : (w_hit ? S_DONE : S_MEM_RD);
         S_MEM_RD, S_MEM_WR: w_next = mem_ack ? S_DONE : r_state;
         S_DONE:             w_next = S_IDLE;
         default:            w_next = S_IDLE;
      endcase
   end
   // mem_req follows the state so an async reset drops it at once
   always_comb begin
      ready   = (r_state == S_DONE);
      mem_req = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_rwb   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_dout  <= '0;
         r_hit   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rwb   <= RWB;
            r_addr  <= Address;
            r_wdata <= Data;
         end
         if (r_state == S_LOOKUP) begin
            r_hit <= w_hit;
            if (r_rwb && w_hit) r_dout <= w_rdata;
         end
         if (w_fill) r_dout <= mem_rdata;
      end
   assign MemSysOut = r_dout;
   assign Hit       = r_hit;
   assign mem_rwb   = r_rwb;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
`ifdef MEM_CACHE_STATS_EN
   logic [15:0] r_hit_cnt, r_acc_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_hit_cnt <= '0;
         r_acc_cnt <= '0;
      end else if (ready) begin
         if (r_acc_cnt != 16'hFFFF) r_acc_cnt <= r_acc_cnt + 16'd1;
         if (r_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      end
   assign hit_cnt = r_hit_cnt;
   assign acc_cnt = r_acc_cnt;
`else
   assign hit_cnt = '0;
   assign acc_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_cache_sa.sv
// tb_mem_cache_sa: directed table plus corner sequences and random accesses against a reference model
module tb_mem_cache_sa;
   logic       clk = 1'b0, reset, req, RWB, flush, mem_ack;
   logic [5:0] Address, mem_addr;
   logic [7:0] Data, MemSysOut, mem_wdata, mem_rdata;
   logic       ready, Hit, mem_req, mem_rwb;
   logic [15:0] hit_cnt, acc_cnt;

   mem_cache_sa dut (
      .clk(clk), .reset(reset), .req(req), .RWB(RWB), .Address(Address), .Data(Data),
      .flush(flush), .MemSysOut(MemSysOut), .ready(ready), .Hit(Hit), .mem_req(mem_req),
      .mem_rwb(mem_rwb), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .hit_cnt(hit_cnt), .acc_cnt(acc_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rwb;
      logic [5:0] a;
      logic [7:0] d;
      logic       hit;
      logic       chk_d;
      logic [7:0] dout;
      int         cyc;
   } vec_t;

   int checks = 0, errors = 0;
   logic [7:0] mem [64];
   logic [7:0] ref_mem [64];
   logic       mv [4][2];
   logic [3:0] mt [4][2];
   int         mrr [4];
   int         m_hits, m_accs, rsp_lat;
   vec_t       tv [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic m_hit(input logic [5:0] a);
      return (mv[a[1:0]][0] && mt[a[1:0]][0] == a[5:2]) || (mv[a[1:0]][1] && mt[a[1:0]][1] == a[5:2]);
   endfunction

   task automatic m_fill(input logic [5:0] a);
      int v;
      v = !mv[a[1:0]][0] ? 0 : (!mv[a[1:0]][1] ? 1 : mrr[a[1:0]]);
      mv[a[1:0]][v] = 1'b1;
      mt[a[1:0]][v] = a[5:2];
      mrr[a[1:0]] = (mrr[a[1:0]] + 1) % 2;
   endtask

   task automatic m_clear(input logic rr_too);
      for (int s = 0; s < 4; s++) begin
         mv[s][0] = 1'b0;
         mv[s][1] = 1'b0;
         if (rr_too) mrr[s] = 0;
      end
   endtask

   // Backing memory: acks on the third cycle of mem_req
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      rsp_lat = 0;
      forever begin
         @(negedge clk);
         if (mem_ack) mem_ack = 1'b0;
         else if (mem_req) begin
            if (rsp_lat == 2) begin
               mem_ack = 1'b1;
               rsp_lat = 0;
               if (mem_rwb) mem_rdata = mem[mem_addr];
               else mem[mem_addr] = mem_wdata;
            end else rsp_lat++;
         end else rsp_lat = 0;
      end
   end

   task automatic access(input logic rwb, input logic [5:0] a, input logic [7:0] d, input int flush_at,
                         output logic hit, output logic [7:0] dout, output int cyc);
      logic ph;
      ph = m_hit(a);
      @(negedge clk);
      req = 1'b1; RWB = rwb; Address = a; Data = d;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         flush = (cyc == flush_at);
      end while (!ready && cyc < 40);
      req = 1'b0;
      flush = 1'b0;
      hit = Hit;
      dout = MemSysOut;
      chk("ready_timeout", ready, 1);
      chk("mem_req_dropped", mem_req, 0);
      @(negedge clk);
      chk("ready_one_cycle", ready, 0);
      if (rwb && !ph) m_fill(a);
      if (!rwb) ref_mem[a] = d;
      if (ph) m_hits++;
      m_accs++;
   endtask

   task automatic run_vec(input string nm, input vec_t v, input int flush_at);
      logic h;
      logic [7:0] q;
      int c;
      access(v.rwb, v.a, v.d, flush_at, h, q, c);
      chk({nm, "_hit"}, h, v.hit);
      chk({nm, "_cyc"}, c, v.cyc);
      if (v.chk_d) chk({nm, "_data"}, q, v.dout);
   endtask

   initial begin
      logic       seen, rwb, ph, h;
      logic [5:0] a;
      logic [7:0] d, q;
      int         c;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 8'(i + 16);
         ref_mem[i] = 8'(i + 16);
      end
      m_clear(1'b1);
      m_hits = 0;
      m_accs = 0;
      tv[0]  = '{1'b1, 6'h05, 8'h00, 1'b0, 1'b1, 8'h15, 5};
      tv[1]  = '{1'b1, 6'h05, 8'h00, 1'b1, 1'b1, 8'h15, 2};
      tv[2]  = '{1'b0, 6'h05, 8'hAA, 1'b1, 1'b0, 8'h00, 5};
      tv[3]  = '{1'b1, 6'h05, 8'h00, 1'b1, 1'b1, 8'hAA, 2};
      tv[4]  = '{1'b0, 6'h22, 8'h55, 1'b0, 1'b0, 8'h00, 5};
      tv[5]  = '{1'b1, 6'h22, 8'h00, 1'b0, 1'b1, 8'h55, 5};
      tv[6]  = '{1'b1, 6'h03, 8'h00, 1'b0, 1'b1, 8'h13, 5};
      tv[7]  = '{1'b1, 6'h07, 8'h00, 1'b0, 1'b1, 8'h17, 5};
      tv[8]  = '{1'b1, 6'h0B, 8'h00, 1'b0, 1'b1, 8'h1B, 5};
      tv[9]  = '{1'b1, 6'h03, 8'h00, 1'b0, 1'b1, 8'h13, 5};
      tv[10] = '{1'b1, 6'h0B, 8'h00, 1'b1, 1'b1, 8'h1B, 2};
      tv[11] = '{1'b1, 6'h07, 8'h00, 1'b0, 1'b1, 8'h17, 5};
      tv[12] = '{1'b1, 6'h3F, 8'h00, 1'b0, 1'b1, 8'h4F, 5};
      tv[13] = '{1'b1, 6'h3F, 8'h00, 1'b1, 1'b1, 8'h4F, 2};
      tv[14] = '{1'b1, 6'h00, 8'h00, 1'b0, 1'b1, 8'h10, 5};
      tv[15] = '{1'b1, 6'h00, 8'h00, 1'b1, 1'b1, 8'h10, 2};
      reset = 1'b1; req = 1'b0; RWB = 1'b1; Address = '0; Data = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {MemSysOut, Hit, ready, mem_req, mem_rwb, mem_addr, mem_wdata}, 0);
      chk("reset_counters", {hit_cnt, acc_cnt}, 0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), tv[i], 0);
      chk("write_through_05", mem[6'h05], 8'hAA);
      chk("write_through_22", mem[6'h22], 8'h55);

      // flush with req: req dropped, all lines invalidated
      @(negedge clk);
      flush = 1'b1; req = 1'b1; RWB = 1'b1; Address = 6'h05;
      @(negedge clk);
      flush = 1'b0; req = 1'b0;
      m_clear(1'b0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= ready | mem_req;
      end
      chk("flush_req_dropped", seen, 0);
      run_vec("flush_rd05", '{1'b1, 6'h05, 8'h00, 1'b0, 1'b1, 8'hAA, 5}, 0);
      run_vec("flush_busy_rd00", '{1'b1, 6'h00, 8'h00, 1'b0, 1'b1, 8'h10, 5}, 3);
      run_vec("flush_ignored_rd05", '{1'b1, 6'h05, 8'h00, 1'b1, 1'b1, 8'hAA, 2}, 0);
      run_vec("flush_ignored_rd00", '{1'b1, 6'h00, 8'h00, 1'b1, 1'b1, 8'h10, 2}, 0);

      // reset while waiting on memory
      @(negedge clk);
      req = 1'b1; RWB = 1'b1; Address = 6'h2A;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!mem_req && c < 10);
      chk("rst_reached_mem_rd", mem_req, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_mem_req_low", mem_req, 0);
      chk("rst_outputs", {MemSysOut, Hit, ready, mem_rwb, mem_addr, mem_wdata}, 0);
      chk("rst_counters", {hit_cnt, acc_cnt}, 0);
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen |= ready;
      end
      reset = 1'b0;
      req = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen |= ready | mem_req;
      end
      chk("rst_no_ready", seen, 0);
      m_clear(1'b1);
      m_hits = 0;
      m_accs = 0;
      run_vec("rst_rd05", '{1'b1, 6'h05, 8'h00, 1'b0, 1'b1, 8'hAA, 5}, 0);

      for (int i = 0; i < 100; i++) begin
         rwb = ($urandom_range(0, 3) != 0);
         a = 6'($urandom_range(0, 15));
         d = 8'($urandom);
         ph = m_hit(a);
         access(rwb, a, d, 0, h, q, c);
         chk($sformatf("rnd%0d_hit", i), h, ph);
         chk($sformatf("rnd%0d_cyc", i), c, (rwb && ph) ? 2 : 5);
         if (rwb) chk($sformatf("rnd%0d_data", i), q, ref_mem[a]);
      end
      @(negedge clk);
`ifdef MEM_CACHE_STATS_EN
      chk("hit_cnt", 32'(hit_cnt), m_hits);
      chk("acc_cnt", 32'(acc_cnt), m_accs);
`else
      chk("hit_cnt_tied", 32'(hit_cnt), 0);
      chk("acc_cnt_tied", 32'(acc_cnt), 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_cache_sa.md
MEM_CACHE_SA -- requirements
Module: mem_cache_sa

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 6, word-address width in bits.
REQ-003 SHALL have parameter SETS, default 4, set count, a power of two and at least 2.
REQ-004 SHALL have parameter WAYS, default 2, associativity, 1 to 8.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port req  in  1  CPU request; held high until ready.
REQ-008 SHALL have port RWB  in  1  1=read, 0=write.
REQ-009 SHALL have port Address  in  AW  CPU word address.
REQ-010 SHALL have port Data  in  DW  CPU write data.
REQ-011 SHALL have port flush  in  1  invalidate-all pulse.
REQ-012 SHALL have port MemSysOut  out  DW  read data, valid while ready=1.
REQ-013 SHALL have port ready  out  1  one-cycle completion pulse.
REQ-014 SHALL have port Hit  out  1  access hit, valid while ready=1.
REQ-015 SHALL have port mem_req, mem_rwb, mem_addr[AW], mem_wdata[DW]  out  backing-memory request, held until mem_ack.
REQ-016 SHALL have port mem_rdata[DW], mem_ack  in  backing-memory response.
REQ-017 SHALL have port hit_cnt[15:0], acc_cnt[15:0]  out  statistics counters.

Function
REQ-018 SHALL split Address into index = low log2(SETS) bits and tag = remaining bits; one word per line.
REQ-019 SHALL implement FSM states IDLE, LOOKUP, MEM_RD, MEM_WR, DONE.
REQ-020 SHALL, in IDLE with req=1 and flush=0, register RWB, Address and Data, then enter LOOKUP.
REQ-021 SHALL, in LOOKUP on a read hit, register the way data into MemSysOut, set Hit=1 and enter DONE, so ready rises 2 cycles after req is accepted.
REQ-022 SHALL, in LOOKUP on a read miss, set Hit=0 and enter MEM_RD.
REQ-023 SHALL, in MEM_RD on mem_ack, fill the victim way (valid, tag, data), set MemSysOut=mem_rdata and enter DONE.
REQ-024 SHALL, in LOOKUP on a write, overwrite the data of a hit way and enter MEM_WR; a write miss SHALL NOT allocate (write-through, no-write-allocate).
REQ-025 SHALL, in MEM_WR on mem_ack, enter DONE.
REQ-026 SHALL, in DONE, assert ready for exactly one cycle and then return to IDLE.
REQ-027 SHALL choose the victim as the first invalid way, otherwise the per-set round-robin pointer, and SHALL advance that pointer modulo WAYS on each fill.
REQ-028 SHALL keep mem_req and its address/data stable from entry to MEM_RD/MEM_WR until the mem_ack cycle; mem_req SHALL drop in the cycle after ack.
REQ-029 SHALL ignore req in any state other than IDLE.
REQ-030 SHALL, on flush in IDLE, clear all valid bits in one cycle; flush together with req SHALL take priority and drop the req for that cycle; flush outside IDLE SHALL be ignored.
REQ-031 SHALL, on each ready pulse, increment acc_cnt and, if Hit=1, increment hit_cnt; both SHALL saturate at 16'hFFFF.

Reset
REQ-032 SHALL, on reset, force state IDLE, clear all valid bits and round-robin pointers, and drive MemSysOut, Hit, ready, mem_req, mem_rwb, mem_addr, mem_wdata, hit_cnt and acc_cnt to 0.
REQ-033 SHALL, when reset asserts mid-transaction, abandon the access with no ready pulse; mem_req SHALL drop immediately.

Configuration
REQ-034 SHALL, with macro MEM_CACHE_STATS_EN defined, implement hit_cnt and acc_cnt per REQ-031.
REQ-035 SHALL, without MEM_CACHE_STATS_EN, tie hit_cnt and acc_cnt to 0 and synthesise no counter logic.

Structure
REQ-036 SHALL place the FSM state typedef and the default DW/AW/SETS/WAYS constants in shared package mem_cache_pkg.
REQ-037 SHALL implement the valid/tag/data storage and hit-way compare in sub-module cache_way_array, instantiated once.

Verification (DW=8, AW=6, SETS=4, WAYS=2; memory pre-loaded with mem[a]=a+8'h10; ack latency 3 cycles)
REQ-038 SHALL verify: read 6'h05 twice -> first ready with Hit=0 and MemSysOut=8'h15; second ready with Hit=1 and MemSysOut=8'h15, arriving 2 cycles after accept.
REQ-039 SHALL verify: read 6'h01, 6'h05, 6'h09 (all index 1), then 6'h01 -> the third read fills over way 0, so the final read misses.
REQ-040 SHALL verify: write 8'hAA to cached 6'h05, then read 6'h05 -> mem_wdata=8'hAA with mem_req held until ack; the read hits and returns 8'hAA.
REQ-041 SHALL verify: write to uncached 6'h22, then read 6'h22 -> the read misses (no allocate).
REQ-042 SHALL verify: flush and req in the same cycle, then read a previously cached address -> req dropped, and the read misses.
REQ-043 SHALL verify: reset pulsed during MEM_RD -> mem_req low, no ready pulse, counters 0; 100 random accesses -> hit_cnt equals the reference-model hit count.
